// File: rtl/alu_pkg.sv
// Shared types for the sequential ALU: opcodes, FSM states and the
// shift-class helper used when deciding whether an op takes the serial path.
package alu_pkg;

    typedef enum logic [3:0] {
        OP_AND  = 4'd0,
        OP_OR   = 4'd1,
        OP_XOR  = 4'd2,
        OP_ADD  = 4'd3,
        OP_SUB  = 4'd4,
        OP_SLT  = 4'd5,
        OP_SLTE = 4'd6,
        OP_EQ   = 4'd7,
        OP_ADC  = 4'd8,
        OP_SBB  = 4'd9,
        OP_SHL  = 4'd10,
        OP_SHR  = 4'd11,
        OP_SRA  = 4'd12,
        OP_ROL  = 4'd13,
        OP_ROR  = 4'd14,
        OP_RSVD = 4'd15
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } alu_state_e;

    function automatic logic is_shift(alu_op_e o);
        return (o == OP_SHL) || (o == OP_SHR) || (o == OP_SRA) ||
               (o == OP_ROL) || (o == OP_ROR);
    endfunction

endpackage

// File: rtl/alu_shift_step.sv
// One-bit shift/rotate of a WIDTH-bit word. The top level feeds the output
// back through its working register, so n steps cost n cycles.
module alu_shift_step
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] d,
    input  alu_op_e          mode,
    output logic [WIDTH-1:0] q
);

    // Select the single-bit move for the current shift mode
    always_comb begin
        q = d;
        case (mode)
            OP_SHL:  q = {d[WIDTH-2:0], 1'b0};
            OP_SHR:  q = {1'b0, d[WIDTH-1:1]};
            OP_SRA:  q = {d[WIDTH-1], d[WIDTH-1:1]};
            OP_ROL:  q = {d[WIDTH-2:0], d[WIDTH-1]};
            OP_ROR:  q = {d[0], d[WIDTH-1:1]};
            default: q = d;
        endcase
    end

endmodule

// File: rtl/alu_seq.sv
// Handshaked ALU with registered result/flags, a chained carry register and a
// serial shifter. Non-shift ops (and shifts by zero) complete in one cycle;
// shifts by n>0 spend n cycles in SHIFT before presenting the result.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter bit SIGNED_CMP = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] op1,
    input  logic [WIDTH-1:0] op2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             carry,
    output logic             equal,
    output logic             less_than,
    output logic             busy
);

    localparam int SHW = $clog2(WIDTH);

    alu_state_e       state_q;
    alu_op_e          mode_q;
    logic [WIDTH-1:0] work_q;
    logic [WIDTH-1:0] result_q;
    logic [SHW-1:0]   cnt_q;
    logic             carry_q;
    logic             carry_flag_q;
    logic             zero_q;
    logic             equal_q;
    logic             lt_q;
    logic             eq_pend_q;
    logic             lt_pend_q;

    alu_op_e          op_e;
    logic             accept;
    logic [SHW-1:0]   amt;
    logic             cin;
    logic [WIDTH:0]   sum_d;
    logic [WIDTH:0]   diff_d;
    logic             eq_d;
    logic             lt_d;
    logic [WIDTH-1:0] res_d;
    logic             carry_d;
    logic             carry_upd;
    logic             rsvd;
    logic             zero_d;
    logic             cflag_d;
    logic [WIDTH-1:0] step_q;

    assign op_e      = alu_op_e'(op);
    assign in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
    assign accept    = in_valid && in_ready;
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign amt       = op2[SHW-1:0];
    assign rsvd      = (op_e == OP_RSVD);

    assign result    = result_q;
    assign zero      = zero_q;
    assign carry     = carry_flag_q;
    assign equal     = equal_q;
    assign less_than = lt_q;

    // Carry-in only participates for the chained variants; carry_q is already
    // registered when an ADC/SBB is accepted on the previous op's handshake.
    assign cin    = ((op_e == OP_ADC) || (op_e == OP_SBB)) ? carry_q : 1'b0;
    assign sum_d  = {1'b0, op1} + {1'b0, op2} + {{WIDTH{1'b0}}, cin};
    assign diff_d = {1'b0, op1} - {1'b0, op2} - {{WIDTH{1'b0}}, cin};
    assign eq_d   = (op1 == op2);
    assign lt_d   = SIGNED_CMP ? ($signed(op1) < $signed(op2)) : (op1 < op2);

    alu_shift_step #(.WIDTH(WIDTH)) u_step (
        .d    (work_q),
        .mode (mode_q),
        .q    (step_q)
    );

    // Single-cycle result for the op presented at the inputs
    always_comb begin
        res_d     = op1 & op2;
        carry_d   = carry_q;
        carry_upd = 1'b0;
        case (op_e)
            OP_AND:  res_d = op1 & op2;
            OP_OR:   res_d = op1 | op2;
            OP_XOR:  res_d = op1 ^ op2;
            OP_ADD, OP_ADC: begin
                res_d     = sum_d[WIDTH-1:0];
                carry_d   = sum_d[WIDTH];
                carry_upd = 1'b1;
            end
            OP_SUB, OP_SBB: begin
                res_d     = diff_d[WIDTH-1:0];
                carry_d   = diff_d[WIDTH];
                carry_upd = 1'b1;
            end
            OP_SLT:  res_d = {{(WIDTH-1){1'b0}}, lt_d};
            OP_SLTE: res_d = {{(WIDTH-1){1'b0}}, lt_d | eq_d};
            OP_EQ:   res_d = {{(WIDTH-1){1'b0}}, eq_d};
            OP_SHL, OP_SHR, OP_SRA, OP_ROL, OP_ROR: res_d = op1;
            default: res_d = op1 & op2;
        endcase
    end

    // Flags for the single-cycle path; the reserved opcode clears all of them
    always_comb begin
        zero_d  = rsvd ? 1'b0 : (res_d == '0);
        cflag_d = rsvd ? 1'b0 : (carry_upd ? carry_d : carry_q);
    end

    // Control FSM, serial shifter, carry chain and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            mode_q       <= OP_AND;
            cnt_q        <= '0;
            result_q     <= '0;
            zero_q       <= 1'b0;
            carry_q      <= 1'b0;
            carry_flag_q <= 1'b0;
            equal_q      <= 1'b0;
            lt_q         <= 1'b0;
            eq_pend_q    <= 1'b0;
            lt_pend_q    <= 1'b0;
        end else if (state_q == SHIFT) begin
            work_q <= step_q;
            cnt_q  <= cnt_q - SHW'(1);
            if (cnt_q == SHW'(1)) begin
                state_q      <= DONE;
                result_q     <= step_q;
                zero_q       <= (step_q == '0);
                carry_flag_q <= carry_q;
                equal_q      <= eq_pend_q;
                lt_q         <= lt_pend_q;
            end
        end else if (accept) begin
            if (is_shift(op_e) && (amt != '0)) begin
                state_q   <= SHIFT;
                work_q    <= op1;
                mode_q    <= op_e;
                cnt_q     <= amt;
                eq_pend_q <= eq_d;
                lt_pend_q <= lt_d;
            end else begin
                state_q      <= DONE;
                result_q     <= res_d;
                zero_q       <= zero_d;
                carry_flag_q <= cflag_d;
                equal_q      <= rsvd ? 1'b0 : eq_d;
                lt_q         <= rsvd ? 1'b0 : lt_d;
                if (carry_upd) begin
                    carry_q <= carry_d;
                end
            end
        end else if ((state_q == DONE) && out_ready) begin
            state_q <= IDLE;
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq: an unsigned 8-bit instance, a signed-compare
// 8-bit instance sharing its stimulus, and a 16-bit instance for carry-out.
module tb_alu_seq;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [3:0]  op = 4'd0;
    logic [7:0]  op1 = 8'h00;
    logic [7:0]  op2 = 8'h00;
    logic [15:0] op1_w = 16'h0000;
    logic [15:0] op2_w = 16'h0000;

    logic       in_ready, out_valid, zero, carry, equal, less_than, busy;
    logic [7:0] result;
    logic       in_ready_s, out_valid_s, zero_s, carry_s, equal_s, less_than_s, busy_s;
    logic [7:0] result_s;
    logic        in_ready_w, out_valid_w, zero_w, carry_w, equal_w, less_than_w, busy_w;
    logic [15:0] result_w;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_seq #(.WIDTH(8), .SIGNED_CMP(1'b0)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .op1(op1), .op2(op2), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .zero(zero), .carry(carry), .equal(equal),
        .less_than(less_than), .busy(busy)
    );

    alu_seq #(.WIDTH(8), .SIGNED_CMP(1'b1)) dut_s (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_s),
        .op(op), .op1(op1), .op2(op2), .out_valid(out_valid_s), .out_ready(out_ready),
        .result(result_s), .zero(zero_s), .carry(carry_s), .equal(equal_s),
        .less_than(less_than_s), .busy(busy_s)
    );

    alu_seq #(.WIDTH(16), .SIGNED_CMP(1'b0)) dut_w (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_w),
        .op(op), .op1(op1_w), .op2(op2_w), .out_valid(out_valid_w), .out_ready(out_ready),
        .result(result_w), .zero(zero_w), .carry(carry_w), .equal(equal_w),
        .less_than(less_than_w), .busy(busy_w)
    );

    task automatic issue(input alu_op_e o, input logic [7:0] a, input logic [7:0] b);
        op        = o;
        op1       = a;
        op2       = b;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid  = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        checks++; if (result !== 8'h00) begin errors++; $display("FAIL reset_result: got %h want 00", result); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if ({zero, carry, equal, less_than} !== 4'b0000) begin errors++; $display("FAIL reset_flags: got %b want 0000", {zero, carry, equal, less_than}); end
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL idle_hold: got valid=%b ready=%b want 0/1", out_valid, in_ready); end
    endtask

    task automatic test_add_adc();
        op1_w = 16'hFFFF;
        op2_w = 16'h0001;
        issue(OP_ADD, 8'hF0, 8'h20);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL add_latency: got out_valid=%b want 1", out_valid); end
        checks++; if (result !== 8'h10) begin errors++; $display("FAIL add_result: got %h want 10", result); end
        checks++; if (carry !== 1'b1 || zero !== 1'b0) begin errors++; $display("FAIL add_flags: got c=%b z=%b want c=1 z=0", carry, zero); end
        checks++; if (result_w !== 16'h0000) begin errors++; $display("FAIL w16_add_result: got %h want 0000", result_w); end
        checks++; if (carry_w !== 1'b1 || zero_w !== 1'b1) begin errors++; $display("FAIL w16_add_flags: got c=%b z=%b want c=1 z=1", carry_w, zero_w); end
        op1_w = 16'h0000;
        op2_w = 16'h0000;
        issue(OP_ADC, 8'h00, 8'h00);
        checks++; if (out_valid !== 1'b1 || result !== 8'h01) begin errors++; $display("FAIL adc_result: got v=%b %h want v=1 01", out_valid, result); end
        checks++; if (carry !== 1'b0) begin errors++; $display("FAIL adc_carry: got %b want 0", carry); end
        issue(OP_SBB, 8'h00, 8'h01);
        checks++; if (result !== 8'hFF || carry !== 1'b1) begin errors++; $display("FAIL sbb_borrow: got %h c=%b want FF c=1", result, carry); end
    endtask

    task automatic test_compare();
        issue(OP_SUB, 8'h05, 8'h05);
        checks++; if (result !== 8'h00 || zero !== 1'b1) begin errors++; $display("FAIL sub_zero: got %h z=%b want 00 z=1", result, zero); end
        checks++; if (equal !== 1'b1 || carry !== 1'b0 || less_than !== 1'b0) begin errors++; $display("FAIL sub_flags: got e=%b c=%b lt=%b want 1/0/0", equal, carry, less_than); end
        issue(OP_SLT, 8'h80, 8'h01);
        checks++; if (result !== 8'h00 || less_than !== 1'b0) begin errors++; $display("FAIL slt_unsigned: got %h lt=%b want 00 lt=0", result, less_than); end
        checks++; if (result_s !== 8'h01 || less_than_s !== 1'b1) begin errors++; $display("FAIL slt_signed: got %h lt=%b want 01 lt=1", result_s, less_than_s); end
        issue(OP_SLTE, 8'h05, 8'h05);
        checks++; if (result !== 8'h01 || equal !== 1'b1) begin errors++; $display("FAIL slte_equal: got %h e=%b want 01 e=1", result, equal); end
        issue(OP_EQ, 8'h03, 8'h04);
        checks++; if (result !== 8'h00 || less_than !== 1'b1 || zero !== 1'b1) begin errors++; $display("FAIL eq_diff: got %h lt=%b z=%b want 00 1 1", result, less_than, zero); end
        issue(OP_SLTE, 8'h0F, 8'h0F);
        issue(OP_RSVD, 8'h0F, 8'h0F);
        checks++; if (result !== 8'h0F) begin errors++; $display("FAIL rsvd_result: got %h want 0F", result); end
        checks++; if ({zero, carry, equal, less_than} !== 4'b0000) begin errors++; $display("FAIL rsvd_flags: got %b want 0000", {zero, carry, equal, less_than}); end
    endtask

    task automatic test_shift();
        issue(OP_XOR, 8'h3C, 8'h00);
        checks++; if (result !== 8'h3C) begin errors++; $display("FAIL xor_result: got %h want 3C", result); end
        issue(OP_SRA, 8'h90, 8'h03);
        for (int i = 0; i < 3; i++) begin
            checks++; if (busy !== 1'b1 || out_valid !== 1'b0 || result !== 8'h3C) begin errors++; $display("FAIL sra_shifting: cycle %0d got busy=%b v=%b res=%h want 1 0 3C", i + 1, busy, out_valid, result); end
            @(posedge clk); #1;
        end
        checks++; if (out_valid !== 1'b1 || result !== 8'hF2) begin errors++; $display("FAIL sra_result: got v=%b %h want v=1 F2", out_valid, result); end
        issue(OP_ROL, 8'h81, 8'h01);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rol_early: got out_valid=%b want 0", out_valid); end
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b1 || result !== 8'h03) begin errors++; $display("FAIL rol_result: got v=%b %h want v=1 03", out_valid, result); end
        issue(OP_SHL, 8'h5A, 8'h08);
        checks++; if (out_valid !== 1'b1 || result !== 8'h5A) begin errors++; $display("FAIL shl_n0: got v=%b %h want v=1 5A", out_valid, result); end
    endtask

    task automatic test_back_pressure();
        issue(OP_AND, 8'hCC, 8'hAA);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        op        = OP_OR;
        op1       = 8'h0F;
        op2       = 8'hF0;
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready: got %b want 0", in_ready); end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checks++; if (result !== 8'h88 || out_valid !== 1'b1 || in_ready !== 1'b0 || zero !== 1'b0) begin errors++; $display("FAIL bp_stable: cycle %0d got %h v=%b r=%b z=%b want 88 1 0 0", i, result, out_valid, in_ready, zero); end
        end
        out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready: got %b want 1", in_ready); end
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b1 || result !== 8'hFF) begin errors++; $display("FAIL b2b_first: got v=%b %h want v=1 FF", out_valid, result); end
        op  = OP_XOR;
        op1 = 8'hFF;
        op2 = 8'h0F;
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b1 || result !== 8'hF0) begin errors++; $display("FAIL b2b_second: got v=%b %h want v=1 F0", out_valid, result); end
        in_valid = 1'b0;
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL b2b_drain: got v=%b busy=%b want 0 0", out_valid, busy); end
    endtask

    task automatic test_reset_shift();
        issue(OP_ADD, 8'hFF, 8'h02);
        checks++; if (result !== 8'h01 || carry !== 1'b1) begin errors++; $display("FAIL pre_reset_add: got %h c=%b want 01 c=1", result, carry); end
        issue(OP_SHR, 8'hFF, 8'h07);
        @(posedge clk); #1;
        @(posedge clk); #1;
        checks++; if (busy !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL shr_midway: got busy=%b v=%b want 1 0", busy, out_valid); end
        reset     = 1'b1;
        out_ready = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        checks++; if (busy !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL rst_shift_ctrl: got busy=%b v=%b r=%b want 0 0 1", busy, out_valid, in_ready); end
        checks++; if (result !== 8'h00 || {zero, carry, equal, less_than} !== 4'b0000) begin errors++; $display("FAIL rst_shift_data: got %h flags=%b want 00 0000", result, {zero, carry, equal, less_than}); end
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_discard: got out_valid=%b want 0", out_valid); end
        issue(OP_ADC, 8'h00, 8'h00);
        checks++; if (result !== 8'h00 || zero !== 1'b1 || carry !== 1'b0) begin errors++; $display("FAIL rst_chain: got %h z=%b c=%b want 00 1 0", result, zero, carry); end
    endtask

    initial begin
        test_reset();
        test_add_adc();
        test_compare();
        test_shift();
        test_back_pressure();
        test_reset_shift();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
